muldiv_seq: RTL and testbench
=============================

// Module: muldiv_seq
// PURPOSE
//   Multi-cycle multiply/divide unit with architectural HI/LO registers for the MIPS datapath.
//   Executes MULT, MULTU, DIV and DIVU iteratively, plus single-cycle MTHI/MTLO writes.
//   Drives busy so the pipeline stalls any MFHI/MFLO or new mul/div op until the result lands.
//   Replaces the combinational unsigned-only multiplier.
// PARAMETERS
//   WIDTH          32  operand width; HI and LO are each WIDTH bits.
//   BITS_PER_CYCLE 1   bits retired per iteration. Must divide WIDTH (1, 2, 4 legal).
//                      Also sets N = WIDTH/BITS_PER_CYCLE.
// PORTS
//   clk    in   1      rising-edge clock.
//   rst_n  in   1      asynchronous active-low reset.
//   start  in   1      request; sampled only when busy=0.
//   op     in   3      000 MULTU, 001 MULT, 010 DIVU, 011 DIV, 100 MTHI, 101 MTLO; 110/111 no-op.
//   a      in   WIDTH  rs: multiplicand or dividend; MTHI/MTLO data.
//   b      in   WIDTH  rt: multiplier or divisor.
//   busy   out  1      high while a mul/div is in flight (state != IDLE).
//   done   out  1      one-cycle pulse; new HI/LO are visible in that cycle.
//   mfhi   out  WIDTH  HI register.
//   mflo   out  WIDTH  LO register.
// BEHAVIOUR
//   Reset (async, rst_n=0)
//     state=IDLE, busy=0, done=0, mfhi=0, mflo=0, counter=0.
//     Any in-flight op is discarded. Recovery starts at the first clk edge after rst_n rises.
//   States: IDLE, CALC, FIX.
//   IDLE
//     start & op in {MTHI, MTLO}: that register takes a at this edge; stay IDLE; no done pulse.
//     start & mul/div op:
//       - latch |a| and |b| (magnitudes for signed ops, raw values for unsigned);
//       - latch result signs and the divide-by-zero flag (b==0);
//       - counter=N; go to CALC.
//     start & op 110/111: ignored.
//   CALC
//     Each edge retires BITS_PER_CYCLE bits; counter decrements.
//       - Multiply: shift-add into a 2*WIDTH accumulator.
//       - Divide: restoring shift-subtract producing quotient and remainder.
//     Go to FIX on the edge where counter goes 1 -> 0.
//   FIX (one edge)
//     Apply sign correction, write mfhi/mflo, done<=1, go to IDLE.
//   Timing
//     start accepted at edge E0. CALC edges E1..EN. FIX edge EN+1.
//     done=1 and results valid for the cycle after EN+1.
//     WIDTH=32, BPC=1: 33 edges. Latency is fixed; it does not depend on operand values.
//   busy is combinational from state; done is registered and is cleared on every other edge.
//   start while busy=1 is ignored, including MTHI/MTLO; the CPU must stall.
//   mfhi/mflo keep their old values throughout CALC; they change only in FIX, MTHI/MTLO or reset.
//   Multiply: {mfhi,mflo} = full 2*WIDTH product.
//     MULT gives the two's-complement product; the product is negated when sign(a)^sign(b).
//   Divide: mflo = quotient, truncated toward zero; mfhi = remainder, with the sign of the dividend.
//     - Quotient is negated when sign(a)^sign(b).
//     - DIV of INT_MIN by -1: mflo=INT_MIN, mfhi=0 (wraps; no trap).
//     - Divide by zero (DIV or DIVU): mflo=all ones, mfhi=a as latched (raw, unsigned view).
//       Full latency still applies.
//   Operands a and b may change after E0 without affecting the result.
// TESTING
//   1 Reset mid-op: MULTU, then rst_n=0 at cycle 10
//     -> busy=0, mfhi=mflo=0 immediately; no done pulse afterwards.
//   2 MULTU a=FFFFFFFF b=FFFFFFFF
//     -> done at 33rd edge; mfhi=FFFFFFFE, mflo=00000001.
//   3 MULT a=FFFFFFFD(-3) b=00000007
//     -> mfhi=FFFFFFFF, mflo=FFFFFFEB.
//     Repeat as MULTU -> mfhi=00000006, mflo=FFFFFFEB.
//   4 DIV a=FFFFFFF9(-7) b=00000002 -> mflo=FFFFFFFD, mfhi=FFFFFFFF.
//     DIV a=80000000 b=FFFFFFFF -> mflo=80000000, mfhi=00000000.
//   5 DIVU a=12345678 b=0 -> mflo=FFFFFFFF, mfhi=12345678, same latency.
//     MTHI a=DEADBEEF issued while busy -> ignored.
//   6 MTLO a=CAFEF00D from IDLE -> mflo=CAFEF00D next cycle, busy stays 0, no done.
//     Rerun tests 2-4 with BITS_PER_CYCLE=4 -> identical results, done at edge 9.

Source files
------------

// File: rtl/muldiv_seq.sv
// rtl/muldiv_seq.sv - iterative MULT/MULTU/DIV/DIVU unit with architectural HI/LO
// Shared 2*WIDTH accumulator: {hi, lo} for shift-add multiply, {rem, quotient} for restoring divide.
module muldiv_seq #(
  parameter int WIDTH          = 32,
  parameter int BITS_PER_CYCLE = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] mfhi,
  output logic [WIDTH-1:0] mflo
);

  localparam int N  = WIDTH / BITS_PER_CYCLE;
  localparam int CW = $clog2(N + 1);

  typedef enum logic [1:0] {IDLE, CALC, FIX} state_t;

  state_t             state;
  logic [CW-1:0]      cnt;
  logic               is_div;
  logic               neg_res;
  logic               neg_rem;
  logic               div_zero;
  logic [WIDTH-1:0]   a_raw;
  logic [WIDTH-1:0]   opb;
  logic [2*WIDTH-1:0] acc;

  logic               a_neg, b_neg;
  logic [WIDTH-1:0]   a_mag, b_mag;
  logic [2*WIDTH-1:0] acc_step;
  logic [WIDTH:0]     rem_try;
  logic [WIDTH-1:0]   diff;
  logic [WIDTH:0]     sum;
  logic [2*WIDTH-1:0] prod_fix;
  logic [WIDTH-1:0]   quo_fix, rem_fix;

  assign busy = (state != IDLE);

  // op[0] selects the signed variants for all four arithmetic ops
  always_comb begin
    a_neg = op[0] & a[WIDTH-1];
    b_neg = op[0] & b[WIDTH-1];
    a_mag = a_neg ? -a : a;
    b_mag = b_neg ? -b : b;
  end

  always_comb begin
    acc_step = acc;
    rem_try  = '0;
    diff     = '0;
    sum      = '0;
    for (int k = 0; k < BITS_PER_CYCLE; k++) begin
      if (is_div) begin
        rem_try = {acc_step[2*WIDTH-1:WIDTH], acc_step[WIDTH-1]};
        if (rem_try >= {1'b0, opb}) begin
          // partial remainder stays below the divisor, so WIDTH bits suffice
          diff     = rem_try[WIDTH-1:0] - opb;
          acc_step = {diff, acc_step[WIDTH-2:0], 1'b1};
        end else begin
          acc_step = {rem_try[WIDTH-1:0], acc_step[WIDTH-2:0], 1'b0};
        end
      end else begin
        sum      = {1'b0, acc_step[2*WIDTH-1:WIDTH]} + (acc_step[0] ? {1'b0, opb} : '0);
        acc_step = {sum, acc_step[WIDTH-1:1]};
      end
    end
  end

  always_comb begin
    prod_fix = neg_res ? -acc : acc;
    quo_fix  = neg_res ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
    rem_fix  = neg_rem ? -acc[2*WIDTH-1:WIDTH] : acc[2*WIDTH-1:WIDTH];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      cnt      <= '0;
      done     <= 1'b0;
      mfhi     <= '0;
      mflo     <= '0;
      is_div   <= 1'b0;
      neg_res  <= 1'b0;
      neg_rem  <= 1'b0;
      div_zero <= 1'b0;
      a_raw    <= '0;
      opb      <= '0;
      acc      <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            case (op)
              3'b100: mfhi <= a;
              3'b101: mflo <= a;
              3'b000, 3'b001, 3'b010, 3'b011: begin
                is_div   <= op[1];
                neg_res  <= a_neg ^ b_neg;
                neg_rem  <= a_neg;
                div_zero <= (b == '0);
                a_raw    <= a;
                opb      <= b_mag;
                acc      <= {{WIDTH{1'b0}}, a_mag};
                cnt      <= CW'(N);
                state    <= CALC;
              end
              default: ;
            endcase
          end
        end
        CALC: begin
          acc <= acc_step;
          cnt <= cnt - CW'(1);
          if (cnt == CW'(1)) state <= FIX;
        end
        FIX: begin
          if (!is_div) begin
            mfhi <= prod_fix[2*WIDTH-1:WIDTH];
            mflo <= prod_fix[WIDTH-1:0];
          end else if (div_zero) begin
            mfhi <= a_raw;
            mflo <= '1;
          end else begin
            mfhi <= rem_fix;
            mflo <= quo_fix;
          end
          done  <= 1'b1;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_muldiv_seq.sv
// tb/tb_muldiv_seq.sv - directed vectors for muldiv_seq at BITS_PER_CYCLE 1 and 4
// Both instances share stimulus; each is checked against its own result latency.
module tb_muldiv_seq;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [2:0]  op;
  logic [31:0] a, b;
  logic        busy1, done1, busy4, done4;
  logic [31:0] hi1, lo1, hi4, lo4;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  muldiv_seq #(.WIDTH(32), .BITS_PER_CYCLE(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .start(start), .op(op), .a(a), .b(b),
    .busy(busy1), .done(done1), .mfhi(hi1), .mflo(lo1)
  );

  muldiv_seq #(.WIDTH(32), .BITS_PER_CYCLE(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .start(start), .op(op), .a(a), .b(b),
    .busy(busy4), .done(done4), .mfhi(hi4), .mflo(lo4)
  );

  typedef struct {
    string       name;
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] hi;
    logic [31:0] lo;
  } vec_t;

  vec_t vecs[12];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic run_vec(input vec_t v);
    int e1 = -1, e4 = -1, p1 = 0, p4 = 0;
    logic [31:0] hi_before;
    hi_before = hi1;
    @(negedge clk);
    start = 1'b1; op = v.op; a = v.a; b = v.b;
    @(posedge clk);
    #1;
    start = 1'b0; a = $urandom; b = $urandom;
    for (int e = 1; e <= 40; e++) begin
      @(posedge clk);
      #1;
      if (done1) begin p1++; if (e1 < 0) e1 = e; end
      if (done4) begin p4++; if (e4 < 0) e4 = e; end
      if (e == 5) check({v.name, "_hold_hi"}, hi1, hi_before);
    end
    check({v.name, "_hi1"}, hi1, v.hi);
    check({v.name, "_lo1"}, lo1, v.lo);
    check({v.name, "_hi4"}, hi4, v.hi);
    check({v.name, "_lo4"}, lo4, v.lo);
    check({v.name, "_edge1"}, 32'(e1), 32'd33);
    check({v.name, "_edge4"}, 32'(e4), 32'd9);
    check({v.name, "_pulses"}, 32'(p1 + p4), 32'd2);
  endtask

  initial begin
    vecs[0]  = '{"multu_max",  3'b000, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001};
    vecs[1]  = '{"mult_m3x7",  3'b001, 32'hFFFFFFFD, 32'h00000007, 32'hFFFFFFFF, 32'hFFFFFFEB};
    vecs[2]  = '{"multu_m3x7", 3'b000, 32'hFFFFFFFD, 32'h00000007, 32'h00000006, 32'hFFFFFFEB};
    vecs[3]  = '{"div_m7d2",   3'b011, 32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 32'hFFFFFFFD};
    vecs[4]  = '{"div_minm1",  3'b011, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000};
    vecs[5]  = '{"divu_zero",  3'b010, 32'h12345678, 32'h00000000, 32'h12345678, 32'hFFFFFFFF};
    vecs[6]  = '{"div_7dm2",   3'b011, 32'h00000007, 32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD};
    vecs[7]  = '{"divu_100d7", 3'b010, 32'h00000064, 32'h00000007, 32'h00000002, 32'h0000000E};
    vecs[8]  = '{"mult_minsq", 3'b001, 32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000};
    vecs[9]  = '{"div_zero",   3'b011, 32'hFFFFFFF0, 32'h00000000, 32'hFFFFFFF0, 32'hFFFFFFFF};
    vecs[10] = '{"mult_m1x1",  3'b001, 32'hFFFFFFFF, 32'h00000001, 32'hFFFFFFFF, 32'hFFFFFFFF};
    vecs[11] = '{"divu_maxd1", 3'b010, 32'hFFFFFFFF, 32'h00000001, 32'h00000000, 32'hFFFFFFFF};

    rst_n = 1'b0; start = 1'b0; op = 3'b000; a = '0; b = '0;
    repeat (2) @(negedge clk);
    check("rst_busy", {30'd0, busy1, busy4}, 32'd0);
    check("rst_done", {30'd0, done1, done4}, 32'd0);
    check("rst_hi", hi1 | hi4, 32'd0);
    check("rst_lo", lo1 | lo4, 32'd0);
    rst_n = 1'b1;

    for (int i = 0; i < 12; i++) run_vec(vecs[i]);

    // MTHI arriving while busy must be dropped
    begin
      int seen = 0;
      @(negedge clk);
      start = 1'b1; op = 3'b010; a = 32'h12345678; b = 32'h0;
      @(posedge clk); #1; start = 1'b0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      start = 1'b1; op = 3'b100; a = 32'hDEADBEEF;
      @(posedge clk); #1; start = 1'b0;
      for (int e = 0; e < 40 && seen == 0; e++) begin
        @(posedge clk); #1;
        if (done1) seen = 1;
      end
      check("busy_mthi_done", 32'(seen), 32'd1);
      check("busy_mthi_hi1", hi1, 32'h12345678);
      check("busy_mthi_lo1", lo1, 32'hFFFFFFFF);
      check("busy_mthi_hi4", hi4, 32'h12345678);
    end

    repeat (2) @(posedge clk);
    @(negedge clk);
    start = 1'b1; op = 3'b101; a = 32'hCAFEF00D;
    @(posedge clk); #1; start = 1'b0;
    check("mtlo_lo1", lo1, 32'hCAFEF00D);
    check("mtlo_lo4", lo4, 32'hCAFEF00D);
    check("mtlo_hi1", hi1, 32'h12345678);
    check("mtlo_busy", {30'd0, busy1, busy4}, 32'd0);
    check("mtlo_done", {30'd0, done1, done4}, 32'd0);

    @(negedge clk);
    start = 1'b1; op = 3'b110; a = 32'h0;
    @(posedge clk); #1; start = 1'b0;
    check("nop_busy", {30'd0, busy1, busy4}, 32'd0);
    check("nop_lo1", lo1, 32'hCAFEF00D);

    // reset in the middle of a multiply
    begin
      int dn = 0;
      @(negedge clk);
      start = 1'b1; op = 3'b000; a = 32'hFFFFFFFF; b = 32'hFFFFFFFF;
      @(posedge clk); #1; start = 1'b0;
      repeat (9) @(posedge clk);
      check("mid_busy1", 32'(busy1), 32'd1);
      #2 rst_n = 1'b0;
      #1;
      check("midrst_busy", {30'd0, busy1, busy4}, 32'd0);
      check("midrst_hi", hi1 | hi4, 32'd0);
      check("midrst_lo", lo1 | lo4, 32'd0);
      @(negedge clk); rst_n = 1'b1;
      for (int e = 0; e < 40; e++) begin
        @(posedge clk); #1;
        if (done1 || done4) dn++;
      end
      check("midrst_nodone", 32'(dn), 32'd0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
